// File: rtl/cpu_board_display.sv
// rtl/cpu_board_display.sv - step-button debounce/step clock and 4-digit hex display of CPU debug words
module cpu_board_display #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_CYCLES     = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        btn_step,
  input  logic [1:0]  sw_sel,
  input  logic [15:0] sign1,
  input  logic [15:0] sign2,
  input  logic [15:0] sign3,
  input  logic [15:0] sign4,
  output logic        cpu_clk,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_state_e;

  logic          btn_s1_q, btn_s2_q;
  logic [1:0]    sel_s1_q, sel_s2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          cpu_clk_q, cpu_clk_d;
  logic          pulse_q, pulse_d;
  scan_state_e   state_q, state_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [15:0]   snap_q, snap_d;
  logic          first_q, first_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [15:0]   sel_word;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (btn_s2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) stable_d = ~stable_q;
      else                     db_cnt_d = db_cnt_q + DW'(1);
    end
    // Derived from the next stable level so the CPU edge and the pulse align with the flip.
    cpu_clk_d = ~stable_d;
    pulse_d   = stable_d & ~stable_q;
  end

  always_comb begin
    case (sel_s2_q)
      2'd0:    sel_word = sign1;
      2'd1:    sel_word = sign2;
      2'd2:    sel_word = sign3;
      default: sel_word = sign4;
    endcase
    case (state_q)
      DIG0:    nibble = snap_q[3:0];
      DIG1:    nibble = snap_q[7:4];
      DIG2:    nibble = snap_q[11:8];
      default: nibble = snap_q[15:12];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    snap_d     = snap_q;
    an_d       = an_q;
    seg_d      = seg_q;
    first_d    = 1'b0;
    if (first_q) begin
      snap_d = sel_word;
    end else begin
      an_d  = ~(4'b0001 << state_q);
      seg_d = {1'b1, hex7(nibble)};
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_d = '0;
        case (state_q)
          DIG0:    state_d = DIG1;
          DIG1:    state_d = DIG2;
          DIG2:    state_d = DIG3;
          default: state_d = DIG0;
        endcase
        // Outputs lag state by a cycle, so loading here never mixes words within a frame.
        if (state_q == DIG3) snap_d = sel_word;
      end else begin
        scan_cnt_d = scan_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      sel_s1_q   <= 2'b00;
      sel_s2_q   <= 2'b00;
      stable_q   <= 1'b0;
      db_cnt_q   <= '0;
      cpu_clk_q  <= 1'b1;
      pulse_q    <= 1'b0;
      state_q    <= DIG0;
      scan_cnt_q <= '0;
      snap_q     <= '0;
      first_q    <= 1'b1;
      an_q       <= 4'b1111;
      seg_q      <= 8'hFF;
    end else begin
      btn_s1_q   <= btn_step;
      btn_s2_q   <= btn_s1_q;
      sel_s1_q   <= sw_sel;
      sel_s2_q   <= sel_s1_q;
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      cpu_clk_q  <= cpu_clk_d;
      pulse_q    <= pulse_d;
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      snap_q     <= snap_d;
      first_q    <= first_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign cpu_clk    = cpu_clk_q;
  assign step_pulse = pulse_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_cpu_board_display.sv
// tb/tb_cpu_board_display.sv - directed self-checking bench for cpu_board_display
module tb_cpu_board_display;

  logic        CLK, Reset, btn_step;
  logic [1:0]  sw_sel;
  logic [15:0] sign1, sign2, sign3, sign4;
  logic        cpu_clk, step_pulse;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  cpu_board_display #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(2)) dut (
    .CLK(CLK), .Reset(Reset), .btn_step(btn_step), .sw_sel(sw_sel),
    .sign1(sign1), .sign2(sign2), .sign3(sign3), .sign4(sign4),
    .cpu_clk(cpu_clk), .step_pulse(step_pulse), .an(an), .seg(seg)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  logic [3:0] f1_an  [10] = '{4'hF, 4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};
  logic [7:0] f1_seg [10] = '{8'hFF, 8'h8E, 8'h8E, 8'hA4, 8'hA4, 8'h88, 8'h88, 8'hF9, 8'hF9, 8'h8E};
  logic [3:0] f2_an  [16] = '{4'hF, 4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7,
                              4'h7, 4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7};
  logic [7:0] f2_seg [16] = '{8'hFF, 8'h8E, 8'h8E, 8'hA4, 8'hA4, 8'h88, 8'h88, 8'hF9,
                              8'hF9, 8'h8E, 8'h8E, 8'h86, 8'h86, 8'h86, 8'h86, 8'h83};

  initial begin
    int fall, rise, pulses, pulse_at, rel_pulses;
    logic saw_low;
    Reset = 1'b1; btn_step = 1'b0; sw_sel = 2'd0;
    sign1 = 16'h1A2F; sign2 = 16'h1234; sign3 = 16'h5678; sign4 = 16'hBEEF;
    step(2);
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'hFF);
    check("rst_cpu_clk", 16'(cpu_clk), 16'h1);
    check("rst_pulse", 16'(step_pulse), 16'h0);

    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("f1_an%0d", i), 16'(an), 16'(f1_an[i]));
      check($sformatf("f1_seg%0d", i), 16'(seg), 16'(f1_seg[i]));
    end

    #2 Reset = 1'b1;
    #1;
    check("async_an", 16'(an), 16'hF);
    check("async_seg", 16'(seg), 16'hFF);
    check("async_cpu_clk", 16'(cpu_clk), 16'h1);
    @(negedge CLK);
    Reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      check($sformatf("f2_an%0d", i), 16'(an), 16'(f2_an[i]));
      check($sformatf("f2_seg%0d", i), 16'(seg), 16'(f2_seg[i]));
      if (i == 3) sw_sel = 2'd3;
    end

    saw_low = 1'b0; pulses = 0;
    btn_step = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) btn_step = 1'b0;
      step(1);
      if (!cpu_clk) saw_low = 1'b1;
      if (step_pulse) pulses++;
    end
    check("glitch_cpu_clk_low", 16'(saw_low), 16'h0);
    check("glitch_pulses", 16'(pulses), 16'h0);

    fall = -1; pulses = 0; pulse_at = -1;
    btn_step = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (!cpu_clk && fall < 0) fall = i;
      if (step_pulse) begin pulses++; pulse_at = i; end
    end
    check("press_fall_cycle", 16'(fall), 16'd6);
    check("press_pulse_count", 16'(pulses), 16'd1);
    check("press_pulse_cycle", 16'(pulse_at), 16'd6);

    rise = -1; rel_pulses = 0;
    btn_step = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (cpu_clk && rise < 0) rise = i;
      if (step_pulse) rel_pulses++;
    end
    check("release_rise_cycle", 16'(rise), 16'd6);
    check("release_pulses", 16'(rel_pulses), 16'd0);

    btn_step = 1'b1;
    step(5);
    #2 Reset = 1'b1;
    #1 check("db_rst_cpu_clk", 16'(cpu_clk), 16'h1);
    @(negedge CLK);
    Reset = 1'b0;
    fall = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (!cpu_clk && fall < 0) fall = i;
    end
    check("db_rst_fall_cycle", 16'(fall), 16'd6);
    btn_step = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
